// File: rtl/trng_arbiter_if.sv
// Requester-side bus of the TRNG arbiter: word requests, grants and the shared word return path.
// Handshake: a requester holds req high until it sees its rvalid bit pulse; gnt marks the word in
// flight; rvalid is a one-cycle pulse with rdata valid in that cycle. There is no backpressure.
interface trng_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, input gnt, input rvalid, input rdata);
  modport slave  (input req, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/trng_arbiter.sv
// Round-robin sharing of one serial TRNG source; each grant collects one MSB-first word,
// with a repetition-count health test on every sample that latches a sticky failure.
module trng_arbiter #(
  parameter int N_REQ      = 2,
  parameter int WIDTH      = 8,
  parameter int RCT_CUTOFF = 16
) (
  input  logic          clk,
  input  logic          reset,
  trng_arbiter_if.slave bus,
  output logic          health_fail,
  input  logic          trng_bit,
  output logic          trng_req,
  output logic          state_dbg
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, word;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d, idx_q, idx_d, pick_idx, cand;
  logic [RUN_W-1:0] run_q, run_d, run_inc, run_sample;
  logic             found, trip;
  logic             last_bit_q, last_bit_d, hf_q, hf_d, treq_q, treq_d;

  // First asserted request after the previous winner, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign word       = {shift_q, trng_bit};
  assign run_inc    = (&run_q) ? run_q : run_q + 1'b1;
  assign run_sample = (trng_bit == last_bit_q) ? run_inc : RUN_W'(1);
  assign trip       = (run_sample >= RUN_W'(RCT_CUTOFF));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    idx_d      = idx_q;
    run_d      = run_q;
    last_bit_d = last_bit_q;
    hf_d       = hf_q;
    treq_d     = treq_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        treq_d = 1'b0;
        if (!hf_q && found) begin
          gnt_d   = N_REQ'(1) << pick_idx;
          treq_d  = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
          idx_d   = pick_idx;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        shift_d    = word[WIDTH-2:0];
        cnt_d      = cnt_q + 1'b1;
        run_d      = run_sample;
        last_bit_d = trng_bit;
        // A health trip wins over word completion: the in-flight word is dropped.
        if (trip) begin
          hf_d    = 1'b1;
          gnt_d   = '0;
          treq_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          rdata_d  = word;
          rvalid_d = N_REQ'(1) << idx_q;
          gnt_d    = '0;
          treq_d   = 1'b0;
          last_d   = idx_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      idx_q      <= '0;
      run_q      <= '0;
      last_bit_q <= 1'b0;
      hf_q       <= 1'b0;
      treq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      last_bit_q <= last_bit_d;
      hf_q       <= hf_d;
      treq_q     <= treq_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign health_fail = hf_q;
  assign trng_req    = treq_q;
  assign state_dbg   = state_q;
endmodule
